// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg
//   Shared widths and constants for the instruction fetch path. The CPU and
//   the instruction cache already use Inst_Width and Inst_Addr_Width, so the
//   fetch unit takes its default parameters from this package.
package inst_fetch_unit_pkg;

  localparam int Inst_Width      = 32;
  localparam int Inst_Addr_Width = 32;

  // Every instruction is one 32-bit word, so sequential fetch steps by 4.
  localparam int INST_BYTES = 4;

  localparam logic [Inst_Addr_Width-1:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_inst_queue.sv
// inst_queue
//   Circular FIFO of DEPTH entries, each WIDTH bits wide, holding fetched
//   {instruction, pc} pairs until the decoder takes them.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     push, wdata  write wdata at tail
//     pop          advance head
//     flush        discard all entries; takes priority over push and pop
//     head_data    combinational read of the head entry
//     count        number of valid entries (0..DEPTH)
module inst_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = Inst_Width + Inst_Addr_Width
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; entries are only read when count says they
  // are valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wdata;
  end

  assign head_data = mem[head];

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Fetch-side initiator of the PC-to-instruction-cache interface. Issues
//   fetch requests, holds on cache stall, queues returned instructions with
//   their PCs and presents the queue head to decode. A redirect flushes the
//   queue and restarts fetch at the target.
//   Ports:
//     clk, rst                           clock, asynchronous active-low reset
//     icache_ce, icache_addr             fetch request and address
//     icache_stall, icache_enable,
//     icache_inst                        same-cycle cache response
//     dec_valid, dec_inst, dec_pc,
//     dec_ready                          decoder handshake on the queue head
//     redirect_valid, redirect_pc        branch/jump restart
//     fifo_count                         queue occupancy
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                 INST_W   = Inst_Width,
  parameter int                 ADDR_W   = Inst_Addr_Width,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = inst_fetch_unit_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       icache_ce,
  output logic [ADDR_W-1:0]          icache_addr,
  input  logic                       icache_stall,
  input  logic                       icache_enable,
  input  logic [INST_W-1:0]          icache_inst,
  output logic                       dec_valid,
  output logic [INST_W-1:0]          dec_inst,
  output logic [ADDR_W-1:0]          dec_pc,
  input  logic                       dec_ready,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0]        pc;
  logic                     accept;
  logic                     pop;
  logic [INST_W+ADDR_W-1:0] head_data;
  logic                     unused_redirect_bits;

  // Instructions are word aligned; the low target bits carry no information.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Requests are suppressed in reset, when the queue is full, and during a
  // redirect cycle, so a response arriving alongside a redirect is never
  // pushed.
  assign icache_ce   = rst && (fifo_count < CNT_W'(DEPTH)) && !redirect_valid;
  assign icache_addr = rst ? pc : '0;
  assign accept      = icache_ce && !icache_stall && icache_enable;

  // dec_valid is deliberately not gated by redirect_valid; the decoder
  // ignores the head itself in a redirect cycle.
  assign dec_valid = (fifo_count != '0);
  assign pop       = dec_valid && dec_ready;
  assign dec_inst  = rst ? head_data[INST_W+ADDR_W-1:ADDR_W] : '0;
  assign dec_pc    = rst ? head_data[ADDR_W-1:0] : '0;

  // Redirect wins over sequential advance; PC addition wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (accept) begin
      pc <= pc + ADDR_W'(INST_BYTES);
    end
  end

  inst_queue #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (pop),
    .flush     (redirect_valid),
    .wdata     ({icache_inst, pc}),
    .head_data (head_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
//   Directed bench for inst_fetch_unit. The cache model answers every
//   request combinationally with inst = addr ^ 32'hA5A5_0000.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        icache_ce;
  logic [31:0] icache_addr;
  logic        icache_stall;
  logic        icache_enable;
  logic [31:0] icache_inst;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  int error_count = 0;
  int check_count = 0;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .icache_ce      (icache_ce),
    .icache_addr    (icache_addr),
    .icache_stall   (icache_stall),
    .icache_enable  (icache_enable),
    .icache_inst    (icache_inst),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign icache_inst = icache_addr ^ 32'hA5A5_0000;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive all inputs for the current cycle, then let combinational outputs settle.
  task automatic applyStimulus(input logic stall, input logic enable,
                               input logic ready, input logic redir,
                               input logic [31:0] rpc);
    icache_stall   = stall;
    icache_enable  = enable;
    dec_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  // Move just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset state.
    checkOutput("rst_ce",    32'(icache_ce),  32'h0);
    checkOutput("rst_addr",  icache_addr,     32'h0);
    checkOutput("rst_valid", 32'(dec_valid),  32'h0);
    checkOutput("rst_count", 32'(fifo_count), 32'h0);
    repeat (3) tick();
    rst = 1'b1;
    #1;

    // Free run: the first request appears right after reset release.
    checkOutput("run_ce0",    32'(icache_ce), 32'h1);
    checkOutput("run_addr0",  icache_addr,    32'h0);
    checkOutput("run_valid0", 32'(dec_valid), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("run_addr",  icache_addr,     32'(4 * k));
      checkOutput("run_pc",    dec_pc,          32'(4 * (k - 1)));
      checkOutput("run_inst",  dec_inst,        32'(4 * (k - 1)) ^ 32'hA5A5_0000);
      checkOutput("run_count", 32'(fifo_count), 32'h1);
    end

    // Fill: restart at 0 and let the queue fill with decode held off.
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    checkOutput("fill_count", 32'(fifo_count), 32'h4);
    checkOutput("fill_ce",    32'(icache_ce),  32'h0);
    checkOutput("fill_addr",  icache_addr,     32'h10);
    checkOutput("fill_head",  dec_pc,          32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("fill_pop_ce", 32'(icache_ce), 32'h0);
    checkOutput("fill_pop_pc", dec_pc,         32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fill_resume_count", 32'(fifo_count), 32'h3);
    checkOutput("fill_resume_ce",    32'(icache_ce),  32'h1);
    checkOutput("fill_resume_addr",  icache_addr,     32'h10);
    checkOutput("fill_resume_head",  dec_pc,          32'h4);

    // Stall at address 8.
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h8);
    for (int k = 0; k < 5; k++) begin
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_addr",  icache_addr,     32'h8);
      checkOutput("stall_count", 32'(fifo_count), 32'h0);
    end
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("unstall_addr", icache_addr, 32'h8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("unstall_count", 32'(fifo_count), 32'h1);
    checkOutput("unstall_pc",    dec_pc,          32'h8);
    checkOutput("unstall_addr1", icache_addr,     32'hC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("noenable_count", 32'(fifo_count), 32'h1);
    checkOutput("noenable_addr",  icache_addr,     32'hC);

    // Redirect with a full queue.
    repeat (3) tick();
    checkOutput("full_count", 32'(fifo_count), 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h1003);
    checkOutput("redir_ce",    32'(icache_ce), 32'h0);
    checkOutput("redir_valid", 32'(dec_valid), 32'h1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_count", 32'(fifo_count), 32'h0);
    checkOutput("redir_addr",  icache_addr,     32'h1000);
    checkOutput("redir_ce1",   32'(icache_ce),  32'h1);

    // Simultaneous push and pop at count 2, across pointer wrap.
    repeat (2) tick();
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("pp_count", 32'(fifo_count), 32'h2);
      checkOutput("pp_pc",    dec_pc,          32'h1000 + 32'(4 * j));
      checkOutput("pp_inst",  dec_inst,        (32'h1000 + 32'(4 * j)) ^ 32'hA5A5_0000);
      tick();
    end

    // PC wrap.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr0", icache_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_addr1", icache_addr,     32'h0);
    checkOutput("wrap_count", 32'(fifo_count), 32'h1);
    checkOutput("wrap_pc",    dec_pc,          32'hFFFF_FFFC);
    checkOutput("wrap_inst",  dec_inst,        32'h5A5A_FFFC);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b0;
    #1;
    checkOutput("arst_ce",    32'(icache_ce),  32'h0);
    checkOutput("arst_addr",  icache_addr,     32'h0);
    checkOutput("arst_count", 32'(fifo_count), 32'h0);
    checkOutput("arst_valid", 32'(dec_valid),  32'h0);
    checkOutput("arst_pc",    dec_pc,          32'h0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("arel_ce",   32'(icache_ce), 32'h1);
    checkOutput("arel_addr", icache_addr,    32'h0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
